// File: rtl/fifo_256to16_pkg.sv
// rtl/fifo_256to16_pkg.sv - shared widths, lane-count type and state encoding for fifo_256to16
package fifo_256to16_pkg;

    localparam int IN_WIDTH_DEF  = 256;
    localparam int OUT_WIDTH_DEF = 16;
    localparam int LANES_DEF     = IN_WIDTH_DEF / OUT_WIDTH_DEF;
    localparam int CNT_WIDTH_DEF = $clog2(LANES_DEF) + 1;

    typedef logic [CNT_WIDTH_DEF-1:0] lane_cnt_t;

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;

endpackage

// File: rtl/fifo_256to16_if.sv
// rtl/fifo_256to16_if.sv - word-in / lane-out handshake bundle for fifo_256to16
interface fifo_256to16_if
    import fifo_256to16_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
);
    localparam int LP_CNT_WIDTH = $clog2(IN_WIDTH / OUT_WIDTH);

    logic                    i_wr_req;
    logic                    o_wr_ready;
    logic [IN_WIDTH-1:0]     i_data;
    logic [LP_CNT_WIDTH:0]   i_lanes;
    logic                    o_rd_valid;
    logic                    i_rd_ready;
    logic [OUT_WIDTH-1:0]    o_data;
    logic                    o_last;
    logic                    o_busy;

    modport master (
        output i_wr_req, i_data, i_lanes, i_rd_ready,
        input  o_wr_ready, o_rd_valid, o_data, o_last, o_busy
    );

    modport slave (
        input  i_wr_req, i_data, i_lanes, i_rd_ready,
        output o_wr_ready, o_rd_valid, o_data, o_last, o_busy
    );

endinterface

// File: rtl/fifo_256to16.sv
// rtl/fifo_256to16.sv - 256-bit to 16-bit width down-converter with one-word staging slot
module fifo_256to16
    import fifo_256to16_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    fifo_256to16_if.slave  bus
);
    localparam int LANES        = IN_WIDTH / OUT_WIDTH;
    localparam int LP_CNT_WIDTH = $clog2(LANES);
    localparam int CW           = LP_CNT_WIDTH + 1;

    logic [IN_WIDTH-1:0] r_act_word;
    logic [CW-1:0]       r_act_rem;
    logic                r_act_v;
    logic [IN_WIDTH-1:0] r_nxt_word;
    logic [CW-1:0]       r_nxt_rem;
    logic                r_nxt_v;

    logic                w_wr;
    logic                w_rd;
    logic                w_done;
    logic [CW-1:0]       w_in_rem;
    logic [1:0]          w_state;

    // Out-of-range lane counts mean a full word, so act_rem never leaves 1..LANES.
    assign w_in_rem = (bus.i_lanes == '0 || bus.i_lanes > CW'(LANES)) ? CW'(LANES) : bus.i_lanes;

    assign w_wr   = bus.i_wr_req && !r_nxt_v;
    assign w_rd   = r_act_v && bus.i_rd_ready;
    assign w_done = w_rd && (r_act_rem == CW'(1));

    always_comb begin
        w_state = ST_EMPTY;
        if (r_act_v) w_state = r_nxt_v ? ST_FULL : ST_ACTIVE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act_word <= '0;
            r_act_rem  <= '0;
            r_act_v    <= 1'b0;
            r_nxt_word <= '0;
            r_nxt_rem  <= '0;
            r_nxt_v    <= 1'b0;
        end else if (clr) begin
            r_act_v   <= 1'b0;
            r_nxt_v   <= 1'b0;
            r_act_rem <= '0;
        end else begin
            if (w_rd) begin
                if (!w_done) begin
                    r_act_word <= {{OUT_WIDTH{1'b0}}, r_act_word[IN_WIDTH-1:OUT_WIDTH]};
                    r_act_rem  <= r_act_rem - CW'(1);
                end else if (r_nxt_v) begin
                    r_act_word <= r_nxt_word;
                    r_act_rem  <= r_nxt_rem;
                    r_nxt_v    <= 1'b0;
                end else if (w_wr) begin
                    r_act_word <= bus.i_data;
                    r_act_rem  <= w_in_rem;
                end else begin
                    r_act_v <= 1'b0;
                end
            end
            // A write arriving on the done beat of an ACTIVE word went straight into ACT above.
            if (w_wr && !(w_done && !r_nxt_v)) begin
                case (w_state)
                    ST_EMPTY: begin
                        r_act_word <= bus.i_data;
                        r_act_rem  <= w_in_rem;
                        r_act_v    <= 1'b1;
                    end
                    ST_ACTIVE: begin
                        r_nxt_word <= bus.i_data;
                        r_nxt_rem  <= w_in_rem;
                        r_nxt_v    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_wr_ready = !r_nxt_v;
    assign bus.o_rd_valid = r_act_v;
    assign bus.o_data     = r_act_word[OUT_WIDTH-1:0];
    assign bus.o_last     = r_act_v && (r_act_rem == CW'(1));
    assign bus.o_busy     = r_act_v;

endmodule

// File: tb/tb_fifo_256to16.sv
// tb/tb_fifo_256to16.sv - directed and randomised-ready bench for fifo_256to16
module tb_fifo_256to16;
    import fifo_256to16_pkg::*;

    localparam int IW = IN_WIDTH_DEF;
    localparam int OW = OUT_WIDTH_DEF;
    localparam int NL = IW / OW;
    localparam int CW = $clog2(NL) + 1;

    typedef struct {
        logic [OW-1:0] d;
        logic          l;
    } beat_t;

    logic clk;
    logic reset;
    logic clr;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [2:0] seen_states = 3'b000;

    fifo_256to16_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    fifo_256to16 #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (!reset) seen_states[dut.w_state] <= 1'b1;

    function automatic logic [IW-1:0] ramp(input logic [OW-1:0] base);
        logic [IW-1:0] w;
        for (int i = 0; i < NL; i++) w[i*OW +: OW] = base + OW'(i);
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1; clr = 1'b0;
        bus.i_wr_req = 1'b0; bus.i_data = '0; bus.i_lanes = '0; bus.i_rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %0b want 0", bus.o_rd_valid); end
        n_checks++; if (bus.o_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %0b want 0", bus.o_last); end
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.o_busy); end
        n_checks++; if (bus.o_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0000", bus.o_data); end
        n_checks++; if (bus.o_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %0b want 1", bus.o_wr_ready); end
        reset = 1'b0;
    endtask

    task automatic test_single_word();
        @(negedge clk);
        bus.i_rd_ready = 1'b1; bus.i_wr_req = 1'b1; bus.i_data = ramp(16'h0000); bus.i_lanes = CW'(16);
        for (int k = 0; k < NL; k++) begin
            @(negedge clk);
            if (k == 0) bus.i_wr_req = 1'b0;
            n_checks++; if (bus.o_rd_valid !== 1'b1 || bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL single_valid beat %0d got %0b want 1", k, bus.o_rd_valid); end
            n_checks++; if (bus.o_data !== OW'(k)) begin n_fail++; $display("FAIL single_data beat %0d got %h want %h", k, bus.o_data, OW'(k)); end
            n_checks++; if (bus.o_last !== (k == NL - 1)) begin n_fail++; $display("FAIL single_last beat %0d got %0b want %0b", k, bus.o_last, (k == NL - 1)); end
        end
        @(negedge clk);
        n_checks++; if (bus.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %0b want 0", bus.o_rd_valid); end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] exp_d;
        bus.i_wr_req = 1'b1; bus.i_data = ramp(16'h0100); bus.i_lanes = CW'(16); bus.i_rd_ready = 1'b1;
        for (int k = 0; k < 2 * NL; k++) begin
            @(negedge clk);
            exp_d = (k < NL) ? OW'(16'h0100 + k) : OW'(16'h0200 + k - NL);
            n_checks++; if (bus.o_rd_valid !== 1'b1 || bus.o_data !== exp_d) begin n_fail++; $display("FAIL b2b_data beat %0d got %h/%0b want %h/1", k, bus.o_data, bus.o_rd_valid, exp_d); end
            n_checks++; if (bus.o_last !== (k == NL - 1 || k == 2 * NL - 1)) begin n_fail++; $display("FAIL b2b_last beat %0d got %0b", k, bus.o_last); end
            n_checks++; if (bus.o_wr_ready !== (k == 0 || k >= NL)) begin n_fail++; $display("FAIL b2b_wr_ready beat %0d got %0b want %0b", k, bus.o_wr_ready, (k == 0 || k >= NL)); end
            if (k == 0) bus.i_data = ramp(16'h0200);
            if (k == 1) bus.i_wr_req = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (bus.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0b want 0", bus.o_rd_valid); end
    endtask

    task automatic test_partial_word();
        logic [IW-1:0] w;
        logic [OW-1:0] exp_d;
        w = ramp(16'hDE00);
        w[15:0] = 16'hAAAA; w[31:16] = 16'hBBBB; w[47:32] = 16'hCCCC;
        bus.i_wr_req = 1'b1; bus.i_data = w; bus.i_lanes = CW'(3); bus.i_rd_ready = 1'b1;
        for (int k = 0; k < 3 + NL; k++) begin
            @(negedge clk);
            case (k)
                0: exp_d = 16'hAAAA;
                1: exp_d = 16'hBBBB;
                2: exp_d = 16'hCCCC;
                default: exp_d = OW'(16'h0300 + k - 3);
            endcase
            n_checks++; if (bus.o_rd_valid !== 1'b1 || bus.o_data !== exp_d) begin n_fail++; $display("FAIL partial_data beat %0d got %h want %h", k, bus.o_data, exp_d); end
            n_checks++; if (bus.o_last !== (k == 2 || k == 2 + NL)) begin n_fail++; $display("FAIL partial_last beat %0d got %0b", k, bus.o_last); end
            if (k == 0) begin bus.i_data = ramp(16'h0300); bus.i_lanes = CW'(0); end
            if (k == 1) bus.i_wr_req = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (bus.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL partial_drain got %0b want 0", bus.o_rd_valid); end
    endtask

    task automatic test_random_ready();
        beat_t         q[$];
        beat_t         b;
        int            sent = 0;
        int            cycles = 0;
        int            n;
        logic          stalled = 1'b0;
        logic [OW-1:0] held_d = '0;
        logic          held_l = 1'b0;
        logic [IW-1:0] w;
        while ((sent < 100 || q.size() != 0) && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (stalled) begin
                n_checks++;
                if (bus.o_rd_valid !== 1'b1 || bus.o_data !== held_d || bus.o_last !== held_l) begin
                    n_fail++; $display("FAIL rand_stall cycle %0d got %h/%0b want %h/%0b", cycles, bus.o_data, bus.o_last, held_d, held_l);
                end
            end
            bus.i_rd_ready = 1'($urandom_range(0, 1));
            bus.i_wr_req = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            for (int j = 0; j < IW / 32; j++) w[j*32 +: 32] = $urandom;
            bus.i_data = w;
            bus.i_lanes = CW'($urandom_range(0, 20));
            if (bus.i_wr_req && bus.o_wr_ready) begin
                n = (bus.i_lanes == 0 || bus.i_lanes > CW'(NL)) ? NL : int'(bus.i_lanes);
                for (int i = 0; i < n; i++) begin
                    b.d = w[i*OW +: OW]; b.l = (i == n - 1);
                    q.push_back(b);
                end
                sent++;
            end
            if (bus.o_rd_valid && bus.i_rd_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra beat got %h want none", bus.o_data);
                end else begin
                    b = q.pop_front();
                    if (bus.o_data !== b.d || bus.o_last !== b.l) begin
                        n_fail++; $display("FAIL rand_beat got %h/%0b want %h/%0b", bus.o_data, bus.o_last, b.d, b.l);
                    end
                end
            end
            stalled = bus.o_rd_valid && !bus.i_rd_ready;
            held_d = bus.o_data; held_l = bus.o_last;
        end
        bus.i_wr_req = 1'b0; bus.i_rd_ready = 1'b1;
        n_checks++; if (cycles >= 20000) begin n_fail++; $display("FAIL rand_timeout sent %0d pending %0d want 100/0", sent, q.size()); end
        @(negedge clk);
    endtask

    task automatic test_clr();
        bus.i_wr_req = 1'b1; bus.i_data = ramp(16'h0500); bus.i_lanes = CW'(16); bus.i_rd_ready = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) bus.i_wr_req = 1'b0;
            n_checks++; if (bus.o_data !== OW'(16'h0500 + k)) begin n_fail++; $display("FAIL clr_pre beat %0d got %h want %h", k, bus.o_data, OW'(16'h0500 + k)); end
        end
        clr = 1'b1; bus.i_wr_req = 1'b1; bus.i_data = ramp(16'h0600);
        @(negedge clk);
        n_checks++; if (bus.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid got %0b want 0", bus.o_rd_valid); end
        n_checks++; if (bus.o_last !== 1'b0) begin n_fail++; $display("FAIL clr_last got %0b want 0", bus.o_last); end
        n_checks++; if (bus.o_wr_ready !== 1'b1) begin n_fail++; $display("FAIL clr_wr_ready got %0b want 1", bus.o_wr_ready); end
        clr = 1'b0; bus.i_wr_req = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL clr_dropped got %0b want 0", bus.o_rd_valid); end
    endtask

    task automatic test_async_reset();
        bus.i_wr_req = 1'b1; bus.i_data = ramp(16'h0800); bus.i_lanes = CW'(16); bus.i_rd_ready = 1'b0;
        @(negedge clk);
        bus.i_data = ramp(16'h0900);
        @(negedge clk);
        bus.i_wr_req = 1'b0;
        n_checks++; if (bus.o_wr_ready !== 1'b0 || bus.o_rd_valid !== 1'b1) begin n_fail++; $display("FAIL areset_full got rdy %0b vld %0b want 0/1", bus.o_wr_ready, bus.o_rd_valid); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %0b want 0", bus.o_rd_valid); end
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got %0b want 0", bus.o_busy); end
        n_checks++; if (bus.o_data !== 16'h0) begin n_fail++; $display("FAIL areset_data got %h want 0000", bus.o_data); end
        n_checks++; if (bus.o_wr_ready !== 1'b1) begin n_fail++; $display("FAIL areset_wr_ready got %0b want 1", bus.o_wr_ready); end
        @(negedge clk);
        reset = 1'b0;
        bus.i_rd_ready = 1'b1; bus.i_wr_req = 1'b1; bus.i_data = ramp(16'h0A00);
        for (int k = 0; k < NL; k++) begin
            @(negedge clk);
            if (k == 0) bus.i_wr_req = 1'b0;
            n_checks++; if (bus.o_rd_valid !== 1'b1 || bus.o_data !== OW'(16'h0A00 + k)) begin n_fail++; $display("FAIL areset_stream beat %0d got %h want %h", k, bus.o_data, OW'(16'h0A00 + k)); end
            n_checks++; if (bus.o_last !== (k == NL - 1)) begin n_fail++; $display("FAIL areset_last beat %0d got %0b", k, bus.o_last); end
        end
        @(negedge clk);
        n_checks++; if (bus.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL areset_drain got %0b want 0", bus.o_rd_valid); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_partial_word();
        test_random_ready();
        test_clr();
        test_async_reset();
        n_checks++; if (seen_states !== 3'b111) begin n_fail++; $display("FAIL state_cover got %b want 111", seen_states); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_256to16.md
# fifo_256to16

Width down-converter for the outbound path. Accepts one 256-bit word per handshake and emits it as a stream of 16-bit lanes, lowest lane first: lane i is i_data[i*16 +: 16], and lane 0 goes out first. A one-word staging slot lets the next word load while the current word drains, so a continuous stream has no bubbles. It feeds 16-bit consumers such as line output and DMA-to-peripheral paths, and accepts partial words for tail data.

## Interface
- IN_WIDTH, 256, input word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 16, output lane width.
- Derived localparams: LANES = IN_WIDTH/OUT_WIDTH; LP_CNT_WIDTH = $clog2(LANES).
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush of all buffered data.
- i_wr_req  in  1  upstream word valid.
- o_wr_ready  out  1  upstream ready.
- i_data  in  IN_WIDTH  upstream word.
- i_lanes  in  LP_CNT_WIDTH+1  count of valid lanes in i_data. Values 0 or >LANES are treated as LANES.
- o_rd_valid  out  1  downstream lane valid.
- i_rd_ready  in  1  downstream ready.
- o_data  out  OUT_WIDTH  current lane.
- o_last  out  1  current lane is the final valid lane of its word.
- o_busy  out  1  active slot occupied; equal to o_rd_valid.

## Operation
- Two slots:
  - ACT: shift register act_word, remaining-lane count act_rem, valid flag act_v.
  - NXT: word, lane count, valid flag nxt_v.
- States: EMPTY (!act_v), ACTIVE (act_v && !nxt_v), FULL (act_v && nxt_v).
- Write handshake: wr = i_wr_req && o_wr_ready. Read handshake: rd = o_rd_valid && i_rd_ready.
- o_wr_ready = !nxt_v. It is a function of registers only; there is no combinational path from i_rd_ready.
- o_rd_valid = act_v. o_data = act_word[OUT_WIDTH-1:0]. o_last = act_v && (act_rem == 1).
- On rd with act_rem > 1: act_word shifts right by OUT_WIDTH, with zero fill; act_rem decrements.
- On rd with act_rem == 1 (word done):
  - If nxt_v: load NXT into ACT and clear nxt_v.
  - Else if wr: load i_data into ACT directly.
  - Else: clear act_v.
- On wr when not consumed by the rule above:
  - In EMPTY: load into ACT.
  - In ACTIVE: load into NXT.
  - wr cannot occur in FULL.
- Transitions:
  - EMPTY -wr-> ACTIVE.
  - ACTIVE -wr & !done-> FULL.
  - ACTIVE -done & !wr-> EMPTY.
  - FULL -done-> ACTIVE.
  - All other combinations hold state.
- clr has priority over both handshakes. It clears act_v, nxt_v and act_rem, and discards any write offered in the same cycle.
- Lane-count normalisation happens at load time, so act_rem is always in 1..LANES.

## Timing
- Reset values: o_rd_valid=0, o_last=0, o_busy=0, o_data=0, o_wr_ready=1. All data registers are 0 and the state is EMPTY.
- Latency: a word written in cycle N presents lane 0 on o_data with o_rd_valid=1 in cycle N+1.
- Throughput: with i_rd_ready held high and the next word written at least 1 cycle before the last lane, lanes are back-to-back across word boundaries with no idle cycle.
- In FULL, o_wr_ready rises the cycle after the done beat.
- Backpressure: while i_rd_ready=0, o_data, o_last and o_rd_valid hold stable.
- Reset asserted mid-word: all buffered data is lost and outputs go to reset values immediately (asynchronous). Deassertion is synchronised externally.
- clr and reset in the same cycle: reset wins.

## Structure
- Shared package holds:
  - width constants (IN_WIDTH/OUT_WIDTH defaults, LANES);
  - the lane-count type width;
  - state encoding (ST_EMPTY, ST_ACTIVE, ST_FULL), used by the bench for state coverage.
- No sub-module. ACT and NXT are inline register groups; the state is derived from the valid flags rather than held in a separate register.

## Test plan
- Single word 0x000F_000E_..._0001_0000 (lane i = i), i_lanes=16, i_rd_ready=1 -> 16 beats on o_data with values 0..15 in order. o_last only on value 15. o_rd_valid drops after.
- Two words written on consecutive cycles, ready always high -> 32 contiguous beats with no gap. o_wr_ready is low from the cycle after the second write until the cycle after the first word's last beat.
- Random i_rd_ready toggling (50%) over 100 words -> the output stream equals the concatenated lanes and o_data is stable across every stalled cycle.
- i_lanes=3 with data lanes 0xAAAA/0xBBBB/0xCCCC, then i_lanes=0 -> 3 beats with o_last on 0xCCCC, then 16 beats for the second word.
- clr asserted together with i_wr_req during lane 5 of a word -> o_rd_valid=0 the next cycle, the offered word is dropped, and o_wr_ready=1.
- reset asserted asynchronously mid-stream in FULL -> outputs go to reset values before the next clock edge. After release, a new word streams correctly from lane 0.
